// File: rtl/debug_slave_shifter.sv
//------------------------------------------------------------------------------
// Module      : debug_slave_shifter
// Description : Virtual-JTAG debug slave data-register shifter. Latches an
//               instruction on update-IR, captures a per-instruction value on
//               capture-DR, shifts it out LSB first while shifting TDI in, and
//               on update-DR of a full-length scan publishes the register on
//               jdo and emits a one-cycle action / no-action pulse on the
//               channel selected by the latched instruction.
// Ports       : clk, reset (sync, active-high); tck_en qualifies all vs_* and
//               tdi; ir_in instruction; vs_cdr/vs_sdr/vs_udr/vs_uir scan
//               state strobes; tdi serial in; cap_data packed capture values;
//               tdo serial out; jdo accepted register; ir_q latched
//               instruction; take_action/take_no_action one-hot pulses;
//               ir_out {len_err, idle}; idle FSM idle flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debug_slave_shifter #(
    parameter int IR_W    = 2,
    parameter int DR_W    = 38,
    parameter int ACT_BIT = DR_W - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tck_en,
    input  logic [IR_W-1:0]              ir_in,
    input  logic                         vs_cdr,
    input  logic                         vs_sdr,
    input  logic                         vs_udr,
    input  logic                         vs_uir,
    input  logic                         tdi,
    input  logic [(2**IR_W)*DR_W-1:0]    cap_data,
    output logic                         tdo,
    output logic [DR_W-1:0]              jdo,
    output logic [IR_W-1:0]              ir_q,
    output logic [(2**IR_W)-1:0]         take_action,
    output logic [(2**IR_W)-1:0]         take_no_action,
    output logic [1:0]                   ir_out,
    output logic                         idle
);

    localparam int NCH   = 2**IR_W;
    // Count must reach DR_W+1 (saturation value that marks an over-length scan).
    localparam int CNT_W = $clog2(DR_W + 2);

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(DR_W + 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [DR_W-1:0]  sr_q,      sr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [DR_W-1:0]  jdo_q,     jdo_d;
    logic [IR_W-1:0]  ir_reg_q,  ir_reg_d;
    logic             len_err_q, len_err_d;

    // Capture slices unpacked so the instruction can index them directly.
    logic [DR_W-1:0]  w_cap [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_cap_slice
        assign w_cap[k] = cap_data[k*DR_W +: DR_W];
    end

    // Qualified strobes with fixed priority uir > udr > cdr > sdr.
    logic w_uir, w_udr, w_cdr, w_sdr;

    assign w_uir = tck_en & vs_uir;
    assign w_udr = tck_en & vs_udr & ~vs_uir;
    assign w_cdr = tck_en & vs_cdr & ~vs_udr & ~vs_uir;
    assign w_sdr = tck_en & vs_sdr & ~vs_cdr & ~vs_udr & ~vs_uir;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        jdo_d     = jdo_q;
        ir_reg_d  = ir_reg_q;
        len_err_d = len_err_q;

        // ISSUE is a single-cycle state; only update-IR may act during it.
        if (state_q == S_ISSUE) begin
            state_d = S_IDLE;
        end

        if (w_uir) begin
            ir_reg_d  = ir_in;
            cnt_d     = '0;
            len_err_d = 1'b0;
            state_d   = S_IDLE;
        end else if (w_udr) begin
            if (state_q == S_SHIFT) begin
                if (cnt_q == C_CNT_FULL) begin
                    jdo_d   = sr_q;
                    state_d = S_ISSUE;
                end else begin
                    len_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
        end else if (w_cdr) begin
            if (state_q != S_ISSUE) begin
                sr_d    = w_cap[ir_reg_q];
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
        end else if (w_sdr) begin
            if (state_q == S_SHIFT) begin
                sr_d = {tdi, sr_q[DR_W-1:1]};
                if (cnt_q != C_CNT_SAT) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            jdo_q     <= '0;
            ir_reg_q  <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            jdo_q     <= jdo_d;
            ir_reg_q  <= ir_reg_d;
            len_err_q <= len_err_d;
        end
    end

    // The pulse is driven while in ISSUE; a concurrent update-IR or reset
    // cancels it in that same cycle so neither can leak a stale command.
    logic             w_fire;
    logic [NCH-1:0]   w_onehot;

    assign w_fire = (state_q == S_ISSUE) & ~reset & ~w_uir;

    always_comb begin
        w_onehot           = '0;
        w_onehot[ir_reg_q] = 1'b1;
    end

    assign take_action    = (w_fire &  jdo_q[ACT_BIT]) ? w_onehot : '0;
    assign take_no_action = (w_fire & ~jdo_q[ACT_BIT]) ? w_onehot : '0;

    assign tdo    = sr_q[0];
    assign jdo    = jdo_q;
    assign ir_q   = ir_reg_q;
    assign idle   = (state_q == S_IDLE);
    assign ir_out = {len_err_q, idle};

endmodule

`default_nettype wire

// File: doc/debug_slave_shifter.md
DEBUG_SLAVE_SHIFTER -- requirements
Module: debug_slave_shifter

Interface
REQ-001 Parameter IR_W, default 2; instruction register width; NCH = 2**IR_W instruction channels.
REQ-002 Parameter DR_W, default 38; data register width; legal range 8..64.
REQ-003 Parameter ACT_BIT, default DR_W-1; sr bit that selects action vs no-action at update.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tck_en  in  1  one-cycle strobe marking a virtual TCK edge; all vs_* and tdi qualified by it.
REQ-007 ir_in  in  IR_W  instruction value; sampled on qualified vs_uir.
REQ-008 vs_cdr / vs_sdr / vs_udr / vs_uir  in  1 each  capture-DR, shift-DR, update-DR, update-IR states.
REQ-009 tdi  in  1  serial data in.
REQ-010 cap_data  in  NCH*DR_W  capture values; slice k = bits [k*DR_W +: DR_W] for instruction k.
REQ-011 tdo  out  1  serial data out, = sr[0] combinationally.
REQ-012 jdo  out  DR_W  last accepted data register, registered.
REQ-013 ir_q  out  IR_W  latched instruction.
REQ-014 take_action / take_no_action  out  NCH each  one-hot, one-cycle pulses.
REQ-015 ir_out  out  2  status: bit1 = len_err, bit0 = idle.
REQ-016 idle  out  1  high when FSM in IDLE.

Function
REQ-017 FSM states IDLE, SHIFT, ISSUE; vs_* ignored unless tck_en=1 in the same cycle.
REQ-018 Priority on a qualified cycle: vs_uir > vs_udr > vs_cdr > vs_sdr; only highest acts.
REQ-019 vs_uir (any state): ir_q <= ir_in, shift count cleared, len_err cleared, state <= IDLE.
REQ-020 vs_cdr (IDLE or SHIFT): sr <= cap_data slice ir_q, count <= 0, state <= SHIFT.
REQ-021 vs_sdr in SHIFT: sr <= {tdi, sr[DR_W-1:1]}; count increments, saturating at DR_W+1.
REQ-022 vs_sdr in IDLE or ISSUE: no effect on sr or count.
REQ-023 vs_udr in SHIFT with count == DR_W: jdo <= sr, state <= ISSUE.
REQ-024 vs_udr in SHIFT with count != DR_W: jdo unchanged, len_err <= 1 (sticky), state <= IDLE, no pulse.
REQ-025 vs_udr in IDLE: ignored.
REQ-026 ISSUE lasts exactly one cycle: take_action[ir_q] = 1 if jdo[ACT_BIT]=1, else take_no_action[ir_q] = 1; then IDLE.
REQ-027 Pulse appears in the cycle after the qualified vs_udr edge (latency 1); at most one bit of the 2*NCH pulse outputs high at any time.
REQ-028 Qualified vs_* arriving during ISSUE: only vs_uir honoured, and it also suppresses the pulse.
REQ-029 tck_en high with no vs_* asserted: no state change.

Reset
REQ-030 reset=1 at rising edge: state IDLE, sr 0, count 0, jdo 0, ir_q 0, len_err 0, all pulses 0; idle=1, ir_out=2'b01, tdo=0.
REQ-031 Reset overrides every concurrent strobe, including mid-SHIFT and during ISSUE (pulse suppressed).

Verification (IR_W=2, DR_W=38)
REQ-032 uir ir_in=2; cdr; 38 sdr with tdi pattern giving sr=38'h20_0000_00A5; udr -> jdo=38'h20_0000_00A5, take_action=4'b0100 for one cycle one clock after udr.
REQ-033 Same with bit37=0 -> take_no_action=4'b0100 one cycle; take_action stays 0.
REQ-034 ir_q=1, cap_data slice1=38'h3F_1234_5678; cdr then 38 sdr with tdi=0 -> tdo sequence equals slice1 LSB first.
REQ-035 cdr, 37 sdr, udr -> no pulses, jdo unchanged, ir_out=2'b11; subsequent uir -> ir_out=2'b01.
REQ-036 vs_udr and vs_uir asserted together with tck_en -> uir wins, no pulse, ir_q updated; vs_sdr with tck_en=0 -> count unchanged.
REQ-037 reset asserted in SHIFT after 20 sdr -> next cycle all outputs at REQ-030 values.
